// File: rtl/vga_scan_controller_pkg.sv
// Shared VGA timing defaults, colour type and a small window-compare helper
// used by the scan controller.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL    = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL    = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START   = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START   = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

    typedef logic [2:0] rgb_t;
    localparam rgb_t BLACK = 3'b000;

    // Unsigned half-open window test: lo <= v < hi.
    function automatic logic in_window(input logic [9:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_scan_controller_mod_counter.sv
// Modulo-N counter with enable, synchronous reset and a wrap pulse that is
// high on the enabled cycle where the count returns to zero.
module mod_counter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/vga_scan_controller.sv
// 640x480 VGA scan generator: pixel-rate counters, blanked colour register,
// active-low syncs and a one-clock frame tick.
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       visible,
    input  logic [2:0] rgb_in,
    output logic [2:0] rgb_out,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_tick
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap_unused;
    logic             pix_ce;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .cnt   (div_cnt),
        .wrap  (div_wrap_unused)
    );

    assign pix_ce = (div_cnt == DIV_W'(CLK_DIV - 1));

    mod_counter #(.N(H_TOTAL), .W(10)) u_h (
        .clk   (clk),
        .reset (reset),
        .en    (pix_ce),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    // Line counter steps once per completed line; its wrap marks end of frame.
    mod_counter #(.N(V_TOTAL), .W(10)) u_v (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    assign row     = v_cnt;
    assign col     = h_cnt;
    assign visible = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);

    // Colour and syncs share one register stage so they stay aligned at the pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out    <= BLACK;
            hsync_n    <= 1'b1;
            vsync_n    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= v_wrap;
            if (pix_ce) begin
                rgb_out <= visible ? rgb_in : BLACK;
                hsync_n <= !in_window(h_cnt, HS_START, HS_END);
                vsync_n <= !in_window(v_cnt, VS_START, VS_END);
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: default, CLK_DIV=1 and reduced-timing
// instances checked cycle by cycle against closed-form expectations.
module tb_vga_scan_controller;

    localparam int PD  [3] = '{2, 1, 2};
    localparam int HV  [3] = '{640, 640, 20};
    localparam int HF  [3] = '{16, 16, 4};
    localparam int HS  [3] = '{96, 96, 6};
    localparam int HB  [3] = '{48, 48, 4};
    localparam int VV  [3] = '{480, 480, 10};
    localparam int VF  [3] = '{10, 10, 2};
    localparam int VSY [3] = '{2, 2, 2};
    localparam int VB  [3] = '{33, 33, 3};

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       ft;
        logic       vis;
    } obs_t;

    typedef struct {
        int   inst;
        obs_t exp;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0;

    logic [9:0] row_o [3];
    logic [9:0] col_o [3];
    logic       vis_o [3];
    logic [2:0] rgb_i [3];
    logic [2:0] rgb_o [3];
    logic       hs_o  [3];
    logic       vs_o  [3];
    logic       ft_o  [3];
    obs_t       obs_a [3];

    sb_t sbq[$];
    int  checks = 0;
    int  failures = 0;
    int  t = 0;
    logic hs_prev [3];
    logic vs_prev [3];
    int  hs_fall [3];
    int  vs_fall [3];
    int  ft_last [3];
    int  n_hper [3];
    int  n_hw [3];
    int  n_vw [3];
    int  n_fper [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_obs
        assign rgb_i[k] = mode ? 3'b111 : col_o[k][2:0];
        assign obs_a[k] = {row_o[k], col_o[k], rgb_o[k], hs_o[k], vs_o[k], ft_o[k], vis_o[k]};
    end

    vga_scan_controller u_dut (
        .clk(clk), .reset(reset), .row(row_o[0]), .col(col_o[0]), .visible(vis_o[0]),
        .rgb_in(rgb_i[0]), .rgb_out(rgb_o[0]), .hsync_n(hs_o[0]), .vsync_n(vs_o[0]),
        .frame_tick(ft_o[0])
    );

    vga_scan_controller #(.CLK_DIV(PD[1])) u_fast (
        .clk(clk), .reset(reset), .row(row_o[1]), .col(col_o[1]), .visible(vis_o[1]),
        .rgb_in(rgb_i[1]), .rgb_out(rgb_o[1]), .hsync_n(hs_o[1]), .vsync_n(vs_o[1]),
        .frame_tick(ft_o[1])
    );

    vga_scan_controller #(
        .CLK_DIV(PD[2]), .H_VISIBLE(HV[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
        .V_VISIBLE(VV[2]), .V_FRONT(VF[2]), .V_SYNC(VSY[2]), .V_BACK(VB[2])
    ) u_small (
        .clk(clk), .reset(reset), .row(row_o[2]), .col(col_o[2]), .visible(vis_o[2]),
        .rgb_in(rgb_i[2]), .rgb_out(rgb_o[2]), .hsync_n(hs_o[2]), .vsync_n(vs_o[2]),
        .frame_tick(ft_o[2])
    );

    // Expected pins after the t-th edge since reset release: n pixels have
    // elapsed and pixel n-1 is the one held in the output register.
    function automatic obs_t expect_at(input int k, input int tt, input logic m);
        int d, ht, vt, n, p, hp, vp;
        obs_t e;
        d  = PD[k];
        ht = HV[k] + HF[k] + HS[k] + HB[k];
        vt = VV[k] + VF[k] + VSY[k] + VB[k];
        n  = tt / d;
        e.col = 10'(n % ht);
        e.row = 10'((n / ht) % vt);
        e.vis = ((n % ht) < HV[k]) && (((n / ht) % vt) < VV[k]);
        e.ft  = (tt % d == 0) && (n > 0) && (n % (ht * vt) == 0);
        if (n == 0) begin
            e.rgb = 3'b000;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end else begin
            p  = n - 1;
            hp = p % ht;
            vp = (p / ht) % vt;
            e.rgb = (hp < HV[k] && vp < VV[k]) ? (m ? 3'b111 : 3'(hp)) : 3'b000;
            e.hs  = !(hp >= HV[k] + HF[k] && hp < HV[k] + HF[k] + HS[k]);
            e.vs  = !(vp >= VV[k] + VF[k] && vp < VV[k] + VF[k] + VSY[k]);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic events(input int k);
        int d, ht;
        d  = PD[k];
        ht = HV[k] + HF[k] + HS[k] + HB[k];
        if (t == 0) begin
            hs_fall[k] = -1;
            vs_fall[k] = -1;
            ft_last[k] = -1;
        end else begin
            if (hs_prev[k] && !hs_o[k]) begin
                if (hs_fall[k] >= 0) begin
                    chk($sformatf("hsync_period%0d", k), 32'(t - hs_fall[k]), 32'(d * ht));
                    n_hper[k]++;
                end
                chk($sformatf("hsync_fall_col%0d", k), 32'(col_o[k]), 32'(HV[k] + HF[k] + 1));
                hs_fall[k] = t;
            end
            if (!hs_prev[k] && hs_o[k] && hs_fall[k] >= 0) begin
                chk($sformatf("hsync_width%0d", k), 32'(t - hs_fall[k]), 32'(d * HS[k]));
                n_hw[k]++;
            end
            if (vs_prev[k] && !vs_o[k]) begin
                chk($sformatf("vsync_fall_pos%0d", k), 32'({row_o[k], col_o[k]}),
                    32'({10'(VV[k] + VF[k]), 10'd1}));
                vs_fall[k] = t;
            end
            if (!vs_prev[k] && vs_o[k] && vs_fall[k] >= 0) begin
                chk($sformatf("vsync_width%0d", k), 32'(t - vs_fall[k]), 32'(d * ht * VSY[k]));
                n_vw[k]++;
            end
            if (ft_o[k]) begin
                if (ft_last[k] >= 0) begin
                    chk($sformatf("frame_period%0d", k), 32'(t - ft_last[k]),
                        32'(d * ht * (VV[k] + VF[k] + VSY[k] + VB[k])));
                    n_fper[k]++;
                end
                ft_last[k] = t;
            end
        end
        hs_prev[k] = hs_o[k];
        vs_prev[k] = vs_o[k];
    endtask

    // One clock: push expectations, take the edge, then pop and compare.
    task automatic cycle();
        int   tn;
        sb_t  s;
        tn = reset ? 0 : t + 1;
        for (int k = 0; k < 3; k++) begin
            s.inst = k;
            s.exp  = expect_at(k, tn, mode);
            sbq.push_back(s);
        end
        @(posedge clk);
        #1;
        t = tn;
        for (int k = 0; k < 3; k++) begin
            s = sbq.pop_front();
            chk($sformatf("pins%0d_t%0d", s.inst, t), 32'(obs_a[s.inst]), 32'(s.exp));
            events(s.inst);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            hs_prev[k] = 1'b1;
            vs_prev[k] = 1'b1;
            hs_fall[k] = -1;
            vs_fall[k] = -1;
            ft_last[k] = -1;
            n_hper[k] = 0;
            n_hw[k] = 0;
            n_vw[k] = 0;
            n_fper[k] = 0;
        end

        // Power-up reset, then free-run with colour = col[2:0].
        reset = 1'b1;
        mode  = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (4000) cycle();

        // Mid-line, mid-frame reset for 3 clocks; resume with solid white.
        reset = 1'b1;
        repeat (3) cycle();
        mode  = 1'b1;
        reset = 1'b0;
        repeat (6000) cycle();

        chk("hsync_periods_seen0", 32'(n_hper[0] >= 3), 32'd1);
        chk("hsync_widths_seen0", 32'(n_hw[0] >= 5), 32'd1);
        chk("hsync_periods_seen1", 32'(n_hper[1] >= 10), 32'd1);
        chk("frame_periods_seen2", 32'(n_fper[2] >= 6), 32'd1);
        chk("vsync_widths_seen2", 32'(n_vw[2] >= 6), 32'd1);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
